// File: rtl/risc_prog_loader.sv
// risc_prog_loader: boot stage that holds the RISC core in reset, loads a program byte
// stream into local memory, then releases the core and serves instruction fetches until halt.
// Optional build macro CHECKSUM_EN: the final stream byte is a mod-256 checksum of the program.
module risc_prog_loader #(
    parameter int ADDR_W     = 13,
    parameter int PROG_DEPTH = 8192
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              load_valid,
    output logic              load_ready,
    input  logic [7:0]        load_data,
    input  logic              load_last,
    output logic              cpu_reset,
    input  logic              cpu_rd,
    input  logic [12:0]       cpu_addr,
    output logic [7:0]        rom_in,
    input  logic              cpu_halt,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W:0]   byte_count
);

    localparam logic [ADDR_W:0] DEPTH_CNT = (ADDR_W + 1)'(PROG_DEPTH);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_RUN,
        ST_HALTED,
        ST_ERROR
    } state_t;

    state_t            state;
    state_t            state_next;
    logic              accept;
    logic              is_program;
    logic              full;
    logic              store;
    logic              start_load;
    logic [ADDR_W-1:0] addr_lo;
    logic [7:0]        mem [PROG_DEPTH];

`ifdef CHECKSUM_EN
    logic [7:0]        csum;
`endif

    // load_ready is high exactly while in LOAD, so it doubles as the state qualifier here.
    assign accept  = load_valid && load_ready;
    assign full    = (byte_count == DEPTH_CNT);
    assign addr_lo = cpu_addr[ADDR_W-1:0];

`ifdef CHECKSUM_EN
    assign is_program = !load_last;
`else
    assign is_program = 1'b1;
`endif

    assign store = accept && is_program && !full;

    // NOTE: every signal driven in always_comb gets a default first, otherwise a latch is inferred.
    always_comb begin
        state_next = state;
        start_load = 1'b0;
        case (state)
            ST_IDLE, ST_HALTED, ST_ERROR: begin
                if (start) begin
                    state_next = ST_LOAD;
                    start_load = 1'b1;
                end
            end
            ST_LOAD: begin
                if (accept) begin
                    if (is_program && full) begin
                        state_next = ST_ERROR;
                    end else if (load_last) begin
`ifdef CHECKSUM_EN
                        if (byte_count == '0 || load_data != csum) begin
                            state_next = ST_ERROR;
                        end else begin
                            state_next = ST_RUN;
                        end
`else
                        state_next = ST_RUN;
`endif
                    end
                end
            end
            ST_RUN: begin
                if (cpu_halt) begin
                    state_next = ST_HALTED;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Status outputs are registered from the next state so they line up with the state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            load_ready <= 1'b0;
            cpu_reset  <= 1'b1;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            byte_count <= '0;
        end else begin
            load_ready <= (state_next == ST_LOAD);
            cpu_reset  <= (state_next != ST_RUN);
            busy       <= (state_next == ST_LOAD) || (state_next == ST_RUN);
            done       <= (state_next == ST_HALTED);
            err        <= (state_next == ST_ERROR);
            if (start_load) begin
                byte_count <= '0;
            end else if (store) begin
                byte_count <= byte_count + 1'b1;
            end
        end
    end

`ifdef CHECKSUM_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            csum <= 8'h00;
        end else if (start_load) begin
            csum <= 8'h00;
        end else if (store) begin
            csum <= csum + load_data;
        end
    end
`endif

    // NOTE: the program memory has no reset; it is plain RAM and only written by accepted program bytes.
    always_ff @(posedge clk) begin
        if (store) begin
            mem[byte_count[ADDR_W-1:0]] <= load_data;
        end
    end

    // Zero-latency fetch path; bytes past byte_count return whatever an earlier load left there.
    always_comb begin
        rom_in = 8'h00;
        if (state == ST_RUN && cpu_rd && ({1'b0, addr_lo} < DEPTH_CNT)) begin
            rom_in = mem[addr_lo];
        end
    end

endmodule
